// File: rtl/eth_reply_framer_pkg.sv
// Shared Ethernet framing constants and the framer FSM state encoding.
package eth_reply_framer_pkg;

    localparam int          ETH_HDR_BYTES   = 14;
    localparam int          ETH_MIN_PAYLOAD = 46;
    localparam logic [15:0] ETHERTYPE_PDPM  = 16'h88B5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_PAD,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/eth_reply_framer.sv
// Ethernet II reply framer: prepends the 14-byte header to an app payload
// stream, zero-pads to the minimum payload, and repairs short/long payloads
// so every frame is exactly 14 + max(L, 46) bytes.
module eth_reply_framer
    import eth_reply_framer_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h000A35000102,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          LEN_W       = 11
) (
    input  logic             tx_fifo_clock,
    input  logic             tx_fifo_resetn,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  logic [47:0]      hdr_dst_mac,
    input  logic [15:0]      hdr_ethertype,
    input  logic [LEN_W-1:0] hdr_len,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      len_err_cnt
);

    localparam logic [LEN_W-1:0] MIN_PL = LEN_W'(ETH_MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] MAX_PL = LEN_W'(MAX_PAYLOAD);
    localparam logic [3:0]       HDR_LAST_IDX = 4'(ETH_HDR_BYTES - 1);

    state_t           state, state_n;
    logic [3:0]       idx;
    logic [LEN_W-1:0] pcnt;
    logic [LEN_W-1:0] len_q;
    logic [47:0]      dst_q;
    logic [15:0]      type_q;
    logic             drain_pend;
    logic             set_drain;
    logic             len_err;
    logic [7:0]       hdr_byte;

    logic [LEN_W-1:0] pad_end;
    logic             lt_min;
    logic             last_slot;
    logic             m_fire;
    logic             s_fire;

    assign lt_min    = (len_q < MIN_PL);
    assign pad_end   = lt_min ? MIN_PL : len_q;
    assign last_slot = (pcnt == len_q - LEN_W'(1));
    assign m_fire    = m_axis_tvalid & m_axis_tready;
    assign s_fire    = s_axis_tvalid & s_axis_tready;

    // Header byte selected by position: dst MAC, source MAC, ethertype, MSB first.
    always_comb begin
        case (idx)
            4'd0:    hdr_byte = dst_q[47:40];
            4'd1:    hdr_byte = dst_q[39:32];
            4'd2:    hdr_byte = dst_q[31:24];
            4'd3:    hdr_byte = dst_q[23:16];
            4'd4:    hdr_byte = dst_q[15:8];
            4'd5:    hdr_byte = dst_q[7:0];
            4'd6:    hdr_byte = SRC_MAC[47:40];
            4'd7:    hdr_byte = SRC_MAC[39:32];
            4'd8:    hdr_byte = SRC_MAC[31:24];
            4'd9:    hdr_byte = SRC_MAC[23:16];
            4'd10:   hdr_byte = SRC_MAC[15:8];
            4'd11:   hdr_byte = SRC_MAC[7:0];
            4'd12:   hdr_byte = type_q[15:8];
            4'd13:   hdr_byte = type_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Next-state and handshake/data outputs for each framing phase.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        state_n       = state;
        hdr_ready     = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        len_err       = 1'b0;
        set_drain     = 1'b0;
        case (state)
            ST_IDLE: begin
                hdr_ready = 1'b1;
                if (hdr_valid) state_n = ST_HDR;
            end
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
                if (m_fire && idx == HDR_LAST_IDX)
                    state_n = (len_q == '0) ? ST_PAD : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                // Straight pass-through; the frame ends here only when L >= 46.
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = last_slot & ~lt_min;
                if (s_fire) begin
                    if (s_axis_tlast && last_slot) begin
                        state_n = lt_min ? ST_PAD : ST_IDLE;
                    end else if (s_axis_tlast) begin
                        len_err = 1'b1;
                        state_n = ST_PAD;
                    end else if (last_slot) begin
                        len_err = 1'b1;
                        if (lt_min) begin
                            state_n   = ST_PAD;
                            set_drain = 1'b1;
                        end else begin
                            state_n = ST_DRAIN;
                        end
                    end
                end
            end
            ST_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (pcnt == pad_end - LEN_W'(1));
                if (m_fire && m_axis_tlast)
                    state_n = drain_pend ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_fire && s_axis_tlast) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register, header capture, byte counters and statistics.
    always_ff @(posedge tx_fifo_clock or negedge tx_fifo_resetn) begin
        if (!tx_fifo_resetn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pcnt        <= '0;
            len_q       <= '0;
            dst_q       <= '0;
            type_q      <= '0;
            drain_pend  <= 1'b0;
            frame_cnt   <= '0;
            len_err_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state <= state_n;
            if (state == ST_IDLE && hdr_valid) begin
                dst_q      <= hdr_dst_mac;
                type_q     <= hdr_ethertype;
                len_q      <= (hdr_len > MAX_PL) ? MAX_PL : hdr_len;
                idx        <= '0;
                pcnt       <= '0;
                drain_pend <= 1'b0;
            end
            if (state == ST_HDR && m_fire) idx <= idx + 4'd1;
            if ((state == ST_PAYLOAD || state == ST_PAD) && m_fire)
                pcnt <= pcnt + LEN_W'(1);
            if (set_drain) drain_pend <= 1'b1;
            if (m_fire && m_axis_tlast) frame_cnt <= frame_cnt + 32'd1;
            if (len_err && len_err_cnt != 16'hFFFF) len_err_cnt <= len_err_cnt + 16'd1;
        end
    end

endmodule
